// File: rtl/tt_sel_seq_if.sv
// Request/status channel between chip control logic and one select sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface tt_sel_seq_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;
  logic              req_ready;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_valid;

  modport master (
    output req_valid, req_addr, req_ena,
    input  req_ready, done, cur_addr, cur_valid
  );

  modport slave (
    input  req_valid, req_addr, req_ena,
    output req_ready, done, cur_addr, cur_valid
  );
endinterface

// File: rtl/tt_sel_seq.sv
// Select sequencer: turns an address request into reset/increment pulse trains for a
// ripple select counter, then raises the design enable once the counter has settled.
module tt_sel_seq #(
  parameter int ADDR_W   = 10,
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 4,
  parameter bit INCR_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  tt_sel_seq_if.slave req,
  output logic        ctrl_sel_rst_n,
  output logic        ctrl_sel_inc,
  output logic        ctrl_ena
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RST_LO = 3'd1;
  localparam logic [2:0] RST_HI = 3'd2;
  localparam logic [2:0] INC_HI = 3'd3;
  localparam logic [2:0] INC_LO = 3'd4;
  localparam logic [2:0] SETTLE = 3'd5;

  localparam int TMR_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] P_LAST = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] S_LAST = TMR_W'(SETTLE_W - 1);

  logic [2:0]        state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_ena;
  logic              pending;   // a request is in flight, so RST_HI carries on into counting
  logic              accept;
  logic              finish;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_nxt = state;
    tmr_nxt   = tmr + 1'b1;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (req.req_valid && req.req_ready) begin
          accept = 1'b1;
          if (INCR_EN && req.cur_valid && (req.req_addr >= req.cur_addr)) begin
            cnt_nxt   = req.req_addr - req.cur_addr;
            state_nxt = (req.req_addr == req.cur_addr) ? SETTLE : INC_HI;
          end else begin
            cnt_nxt   = req.req_addr;
            state_nxt = RST_LO;
          end
        end
      end
      RST_LO: begin
        if (tmr == P_LAST) begin
          tmr_nxt   = '0;
          state_nxt = RST_HI;
        end
      end
      RST_HI: begin
        if (tmr == P_LAST) begin
          tmr_nxt = '0;
          if (!pending)        state_nxt = IDLE;
          else if (cnt == '0)  state_nxt = SETTLE;
          else                 state_nxt = INC_HI;
        end
      end
      INC_HI: begin
        if (tmr == P_LAST) begin
          tmr_nxt   = '0;
          cnt_nxt   = cnt - 1'b1;
          state_nxt = INC_LO;
        end
      end
      INC_LO: begin
        if (tmr == P_LAST) begin
          tmr_nxt   = '0;
          state_nxt = (cnt == '0) ? SETTLE : INC_HI;
        end
      end
      SETTLE: begin
        if (tmr == S_LAST) begin
          tmr_nxt   = '0;
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        tmr_nxt   = '0;
        state_nxt = RST_LO;
      end
    endcase
  end

  // Controller-facing outputs are registered from the next state so each phase
  // shows on the pins for exactly the cycles the FSM spends in it.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state          <= RST_LO;
      tmr            <= '0;
      cnt            <= '0;
      tgt_addr       <= '0;
      tgt_ena        <= 1'b0;
      pending        <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      req.req_ready  <= 1'b0;
      req.done       <= 1'b0;
      req.cur_addr   <= '0;
      req.cur_valid  <= 1'b0;
    end else begin
      state          <= state_nxt;
      tmr            <= tmr_nxt;
      cnt            <= cnt_nxt;
      ctrl_sel_rst_n <= (state_nxt != RST_LO);
      ctrl_sel_inc   <= (state_nxt == INC_HI);
      req.req_ready  <= (state_nxt == IDLE);
      req.done       <= finish;
      if (accept) begin
        tgt_addr      <= req.req_addr;
        tgt_ena       <= req.req_ena;
        pending       <= 1'b1;
        ctrl_ena      <= 1'b0;
        req.cur_valid <= 1'b0;
      end
      if ((state_nxt == IDLE) && (state != IDLE)) begin
        req.cur_valid <= 1'b1;
        pending       <= 1'b0;
      end
      if (finish) begin
        req.cur_addr <= tgt_addr;
        ctrl_ena     <= tgt_ena;
      end
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Randomised scoreboard bench for tt_sel_seq: the driver predicts each request's
// outcome from the timing rules, and an independent monitor checks every completion.
module tb_tt_sel_seq;
  localparam int AW = 10;
  localparam int P  = 2;
  localparam int S  = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          ena;
    int            acc_cyc;
    int            lat;
    int            npulse;
    int            nrst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sel_seq_if #(.ADDR_W(AW)) a_if ();
  tt_sel_seq_if #(.ADDR_W(AW)) b_if ();
  logic a_rst_n, a_inc, a_ena;
  logic b_rst_n, b_inc, b_ena;

  tt_sel_seq #(.ADDR_W(AW), .PULSE_W(P), .SETTLE_W(S), .INCR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req(a_if),
    .ctrl_sel_rst_n(a_rst_n), .ctrl_sel_inc(a_inc), .ctrl_ena(a_ena)
  );

  tt_sel_seq #(.ADDR_W(AW), .PULSE_W(P), .SETTLE_W(S), .INCR_EN(1'b0)) dut_full (
    .clk(clk), .rst(rst), .req(b_if),
    .ctrl_sel_rst_n(b_rst_n), .ctrl_sel_inc(b_inc), .ctrl_ena(b_ena)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic [AW-1:0] m_cur;
  logic          m_cur_valid;
  bit            b_fin = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Outcome of one request, straight from the path/timing rules.
  function automatic exp_t predict(input logic [AW-1:0] a, input logic e, input bit incr_en,
                                   input logic [AW-1:0] cur, input logic cur_ok, input int t);
    exp_t x;
    bit   inc_path;
    int   n;
    inc_path  = incr_en && (cur_ok === 1'b1) && (a >= cur);
    n         = inc_path ? (int'(a) - int'(cur)) : int'(a);
    x.addr    = a;
    x.ena     = e;
    x.acc_cyc = t;
    x.npulse  = n;
    x.nrst    = inc_path ? 0 : P;
    x.lat     = (inc_path ? 0 : 2 * P) + 2 * P * n + S + 1;
    return x;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [AW-1:0] a, input logic e, input int hold);
    int w;
    w = 0;
    a_if.req_valid = 1'b1;
    a_if.req_addr  = a;
    a_if.req_ena   = e;
    while (a_if.req_ready !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 20000) begin
        fail("accept_timeout");
        a_if.req_valid = 1'b0;
        return;
      end
    end
    sbq.push_back(predict(a, e, 1'b1, m_cur, m_cur_valid, cyc));
    m_cur       = a;
    m_cur_valid = 1'b1;
    @(negedge clk);
    a_if.req_addr = ~a;
    repeat (hold) @(negedge clk);
    a_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0) begin
      @(negedge clk);
      w++;
      if (w > 20000) begin
        fail("drain_timeout");
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl_sel_rst_n", 32'(a_rst_n), 32'd0);
    check("rst_ctrl_sel_inc",   32'(a_inc),   32'd0);
    check("rst_ctrl_ena",       32'(a_ena),   32'd0);
    check("rst_req_ready",      32'(a_if.req_ready), 32'd0);
    check("rst_done",           32'(a_if.done),      32'd0);
    check("rst_cur_valid",      32'(a_if.cur_valid), 32'd0);
    check("rst_cur_addr",       32'(a_if.cur_addr),  32'd0);
    rst         = 1'b0;
    m_cur       = '0;
    m_cur_valid = 1'b1;
    for (int k = 2; k <= 2 * P + 1; k++) begin
      @(negedge clk);
      check("post_rst_sel_rst_n", 32'(a_rst_n),        32'(k > P));
      check("post_rst_req_ready", 32'(a_if.req_ready), 32'(k == 2 * P + 1));
      check("post_rst_done",      32'(a_if.done),      32'd0);
    end
    check("post_rst_cur_addr",  32'(a_if.cur_addr),  32'd0);
    check("post_rst_cur_valid", 32'(a_if.cur_valid), 32'd1);
    check("post_rst_ctrl_ena",  32'(a_ena),          32'd0);
  endtask

  // Monitor: measures pulse shapes per transaction and compares each done against the queue.
  initial begin : monitor
    int   pulses, hi_len, lo_len, rst_lo;
    logic prev_inc;
    exp_t e;
    pulses = 0; hi_len = 0; lo_len = 0; rst_lo = 0; prev_inc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        sbq.delete();
        pulses = 0; hi_len = 0; lo_len = 0; rst_lo = 0; prev_inc = 1'b0;
      end else begin
        if (sbq.size() > 0 && cyc > sbq[0].acc_cyc) begin
          e = sbq[0];
          if (cyc == e.acc_cyc + 1) begin
            check("busy_req_ready", 32'(a_if.req_ready), 32'd0);
            check("busy_ctrl_ena",  32'(a_ena),          32'd0);
            check("busy_cur_valid", 32'(a_if.cur_valid), 32'd0);
          end
          if (a_rst_n === 1'b0) rst_lo++;
          if (a_inc === 1'b1) begin
            if (!prev_inc) begin
              pulses++;
              if (pulses > 1) check("inc_low_width", 32'(lo_len), 32'(P));
              hi_len = 0;
            end
            hi_len++;
          end else begin
            if (prev_inc) begin
              check("inc_high_width", 32'(hi_len), 32'(P));
              lo_len = 0;
            end
            lo_len++;
          end
        end
        if (a_if.done === 1'b1) begin
          if (sbq.size() == 0) begin
            fail("unexpected_done");
          end else begin
            e = sbq.pop_front();
            check("latency",        32'(cyc - e.acc_cyc), 32'(e.lat));
            check("pulse_count",    32'(pulses),          32'(e.npulse));
            check("rst_low_cycles", 32'(rst_lo),          32'(e.nrst));
            check("done_cur_addr",  32'(a_if.cur_addr),   32'(e.addr));
            check("done_cur_valid", 32'(a_if.cur_valid),  32'd1);
            check("done_ctrl_ena",  32'(a_ena),           32'(e.ena));
            check("done_req_ready", 32'(a_if.req_ready),  32'd1);
          end
          pulses = 0; hi_len = 0; lo_len = 0; rst_lo = 0;
        end
        prev_inc = (a_inc === 1'b1);
      end
    end
  end

  // Second instance without the incremental path: every request must take the full path.
  initial begin : full_path_only
    logic [AW-1:0] b_cur;
    exp_t          x;
    int            w;
    b_if.req_valid = 1'b0;
    b_if.req_addr  = '0;
    b_if.req_ena   = 1'b0;
    b_cur          = '0;
    for (int i = 0; i < 2; i++) begin
      logic [AW-1:0] a;
      a = (i == 0) ? AW'(5) : AW'(9);
      w = 0;
      @(negedge clk);
      while (b_if.req_ready !== 1'b1 && w <= 500) begin
        @(negedge clk);
        w++;
      end
      if (w > 500) fail("noincr_ready_timeout");
      b_if.req_valid = 1'b1;
      b_if.req_addr  = a;
      b_if.req_ena   = 1'b1;
      x = predict(a, 1'b1, 1'b0, b_cur, 1'b1, cyc);
      @(negedge clk);
      b_if.req_valid = 1'b0;
      w = 0;
      while (b_if.done !== 1'b1 && w <= 2000) begin
        @(negedge clk);
        w++;
      end
      if (w > 2000) begin
        fail("noincr_done_timeout");
      end else begin
        check("noincr_latency",  32'(cyc - x.acc_cyc), 32'(x.lat));
        check("noincr_cur_addr", 32'(b_if.cur_addr),   32'(a));
        check("noincr_ctrl_ena", 32'(b_ena),           32'd1);
      end
      b_cur = a;
    end
    b_fin = 1'b1;
  end

  initial begin : stimulus
    int w;
    a_if.req_valid = 1'b0;
    a_if.req_addr  = '0;
    a_if.req_ena   = 1'b0;
    m_cur          = '0;
    m_cur_valid    = 1'b0;

    do_reset();

    // Directed: full path down, incremental up, same address, full to zero, max address.
    issue(AW'(7), 1'b1, 0);
    issue(AW'(5), 1'b1, 0);
    issue(AW'(9), 1'b1, 0);
    issue(AW'(9), 1'b1, 0);
    issue(AW'(0), 1'b0, 0);
    issue(AW'(1023), 1'b0, 300);
    drain();

    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] a;
      int            r, gap;
      r = $urandom_range(0, 3);
      case (r)
        0:       a = (m_cur > AW'(1015)) ? m_cur : m_cur + AW'($urandom_range(1, 7));
        1:       a = AW'($urandom_range(0, 63));
        2:       a = m_cur;
        default: a = AW'($urandom_range(0, 31));
      endcase
      issue(a, 1'($urandom_range(0, 1)), 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drain();
        repeat (gap) @(negedge clk);
      end
    end
    drain();

    // Reset during the third increment pulse.
    begin
      int   cnt;
      logic prev;
      cnt  = 0;
      prev = 1'b0;
      w    = 0;
      issue((m_cur <= AW'(1000)) ? m_cur + AW'(10) : AW'(5), 1'b1, 0);
      while (1) begin
        if (a_inc === 1'b1 && !prev) cnt++;
        if (cnt == 3) break;
        prev = (a_inc === 1'b1);
        @(negedge clk);
        w++;
        if (w > 2000) begin
          fail("third_pulse_timeout");
          break;
        end
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ctrl_sel_inc",   32'(a_inc),          32'd0);
      check("midrst_ctrl_ena",       32'(a_ena),          32'd0);
      check("midrst_ctrl_sel_rst_n", 32'(a_rst_n),        32'd0);
      check("midrst_cur_valid",      32'(a_if.cur_valid), 32'd0);
      do_reset();
    end

    issue(AW'(3), 1'b1, 0);
    drain();

    w = 0;
    while (!b_fin && w <= 5000) begin
      @(negedge clk);
      w++;
    end
    if (!b_fin) fail("noincr_finish_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
